hog_gradient: RTL and testbench



---
 rtl/hog_gradient.sv | 153 +++++++++++++++
 tb/tb_hog_gradient.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hog_gradient.sv
// Centred [-1 0 1] horizontal/vertical gradient stage fed by a fall-through FIFO.
// Two line buffers plus column shift registers form the 3x3 cross window; border pixels are dropped.
module hog_gradient #(
  parameter int DSIZE      = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [DSIZE:0]   gx,
  output logic [DSIZE:0]   gy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  function automatic logic [DSIZE:0] grad_sub(input logic [DSIZE-1:0] a, input logic [DSIZE-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  logic [XW-1:0]    x_r;
  logic [YW-1:0]    y_r;
  logic             en_s;
  logic             pop_s;
  logic             emit_s;
  logic             frame_end_s;

  logic [DSIZE-1:0] l1_mem [IMG_WIDTH];
  logic [DSIZE-1:0] l2_mem [IMG_WIDTH];

  logic             p1_r;
  logic             e1_r;
  logic             last1_r;
  logic [DSIZE-1:0] cur_s1_r;
  logic [DSIZE-1:0] up_s1_r;
  logic [DSIZE-1:0] dn_s1_r;

  logic [DSIZE-1:0] cur_d1_r;
  logic [DSIZE-1:0] up_d1_r;
  logic [DSIZE-1:0] up_d2_r;
  logic [DSIZE-1:0] dn_d1_r;

  logic             out_valid_r;
  logic             out_last_r;
  logic [DSIZE:0]   gx_r;
  logic [DSIZE:0]   gy_r;

  // Pipeline enable, pop and emit qualification
  always_comb begin
    en_s        = 1'b0;
    pop_s       = 1'b0;
    emit_s      = 1'b0;
    frame_end_s = 1'b0;
    en_s        = !out_valid_r || out_ready;
    if (rst) begin
      pop_s = 1'b0;
    end else begin
      pop_s = !rempty && en_s;
    end
    emit_s      = (x_r >= XW'(2)) && (y_r >= YW'(2));
    frame_end_s = (x_r == X_LAST) && (y_r == Y_LAST);
  end

  // Raster position counters, advanced only by pops
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r <= '0;
      y_r <= '0;
    end else if (pop_s) begin
      if (x_r == X_LAST) begin
        x_r <= '0;
        if (y_r == Y_LAST) begin
          y_r <= '0;
        end else begin
          y_r <= y_r + YW'(1);
        end
      end else begin
        x_r <= x_r + XW'(1);
      end
    end
  end

  // Line buffers: L1 holds row y-1, L2 holds row y-2; contents never need clearing
  always_ff @(posedge clk) begin
    if (pop_s) begin
      l1_mem[x_r] <= rdata;
      l2_mem[x_r] <= l1_mem[x_r];
    end
  end

  // Stage 1: capture the popped pixel and the two rows above it (read before overwrite)
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_r     <= 1'b0;
      e1_r     <= 1'b0;
      last1_r  <= 1'b0;
      cur_s1_r <= '0;
      up_s1_r  <= '0;
      dn_s1_r  <= '0;
    end else if (en_s) begin
      p1_r    <= pop_s;
      e1_r    <= pop_s && emit_s;
      last1_r <= pop_s && frame_end_s;
      if (pop_s) begin
        cur_s1_r <= rdata;
        up_s1_r  <= l1_mem[x_r];
        dn_s1_r  <= l2_mem[x_r];
      end
    end
  end

  // Stage 2: subtract against the column history, then shift the history on real pixels only
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      gx_r        <= '0;
      gy_r        <= '0;
      cur_d1_r    <= '0;
      up_d1_r     <= '0;
      up_d2_r     <= '0;
      dn_d1_r     <= '0;
    end else if (en_s) begin
      out_valid_r <= e1_r;
      out_last_r  <= e1_r && last1_r;
      if (e1_r) begin
        gx_r <= grad_sub(up_s1_r, up_d2_r);
        gy_r <= grad_sub(cur_d1_r, dn_d1_r);
      end
      if (p1_r) begin
        cur_d1_r <= cur_s1_r;
        up_d1_r  <= up_s1_r;
        up_d2_r  <= up_d1_r;
        dn_d1_r  <= dn_s1_r;
      end
    end
  end

  assign rinc      = pop_s;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign gx        = gx_r;
  assign gy        = gy_r;

endmodule

// File: tb/tb_hog_gradient.sv
// Directed self-checking bench for hog_gradient on a 4x3 image.
module tb_hog_gradient;
  localparam int DSIZE = 8;
  localparam int W     = 4;
  localparam int H     = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic [DSIZE:0]   gx;
  logic [DSIZE:0]   gy;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  int checks   = 0;
  int failures = 0;

  logic [7:0] src [64];
  logic [8:0] cap_gx [16];
  logic [8:0] cap_gy [16];
  logic       cap_last [16];
  int         acc_cyc [16];
  int         pop_cyc [64];
  int         cap_n;
  int         stall_cycles;
  int         stall_viol;
  int         empty_pop;
  int         timed_out;

  always #5 clk = ~clk;

  hog_gradient #(.DSIZE(DSIZE), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .gx(gx), .gy(gy), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  task automatic fill_ramp(input int frames, input bit neg);
    int i;
    int v;
    i = 0;
    for (int f = 0; f < frames; f++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          v = 16 * y + x;
          src[i] = neg ? 8'(255 - v) : 8'(v);
          i++;
        end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; rempty = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Feeds src[0..npix-1] as a fall-through FIFO and records everything accepted downstream.
  task automatic drive(input int npix, input int period, input int stall_len, input int max_cycles);
    int idx;
    int cyc;
    int tail;
    bit stall_done;
    logic [8:0] hold_gx;
    logic [8:0] hold_gy;
    idx = 0; cyc = 0; tail = 0; cap_n = 0;
    stall_cycles = 0; stall_viol = 0; empty_pop = 0; timed_out = 0;
    stall_done = (stall_len == 0);
    hold_gx = 9'd0; hold_gy = 9'd0;
    while (tail < 10) begin
      if (cyc >= max_cycles) begin
        timed_out = 1;
        break;
      end
      @(negedge clk);
      if (idx < npix && (cyc % period) == 0) begin
        rempty = 1'b0; rdata = src[idx];
      end else begin
        rempty = 1'b1; rdata = 8'h00;
      end
      if (!stall_done && out_valid === 1'b1) begin
        out_ready = 1'b0;
        if (stall_cycles == 0) begin
          hold_gx = gx; hold_gy = gy;
        end
        stall_cycles++;
        if (stall_cycles == stall_len) stall_done = 1'b1;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (out_ready == 1'b0 && (rinc !== 1'b0 || out_valid !== 1'b1 || gx !== hold_gx || gy !== hold_gy))
        stall_viol++;
      if (rinc === 1'b1 && rempty) empty_pop++;
      if (rinc === 1'b1) begin
        if (idx < 64) pop_cyc[idx] = cyc;
        idx++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (cap_n < 16) begin
          cap_gx[cap_n] = gx; cap_gy[cap_n] = gy; cap_last[cap_n] = out_last; acc_cyc[cap_n] = cyc;
        end
        cap_n++;
      end
      if (idx >= npix) tail++;
      cyc++;
    end
    @(negedge clk);
    rempty = 1'b1; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rempty = 1'b0; rdata = 8'hA5; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++; if (rinc !== 1'b0) begin failures++; $display("FAIL reset_rinc cyc=%0d got=%b exp=0", c, rinc); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", c, out_valid); end
      checks++; if (gx !== 9'd0) begin failures++; $display("FAIL reset_gx cyc=%0d got=%h exp=000", c, gx); end
      checks++; if (gy !== 9'd0) begin failures++; $display("FAIL reset_gy cyc=%0d got=%h exp=000", c, gy); end
    end
    rst = 1'b0; rempty = 1'b1;
  endtask

  task automatic test_ramp();
    apply_reset();
    fill_ramp(1, 1'b0);
    drive(12, 1, 0, 200);
    checks++; if (timed_out != 0) begin failures++; $display("FAIL ramp_timeout got=%0d exp=0", timed_out); end
    checks++; if (cap_n != 2) begin failures++; $display("FAIL ramp_count got=%0d exp=2", cap_n); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (cap_gx[i] !== 9'd2) begin failures++; $display("FAIL ramp_gx[%0d] got=%h exp=002", i, cap_gx[i]); end
      checks++; if (cap_gy[i] !== 9'd32) begin failures++; $display("FAIL ramp_gy[%0d] got=%h exp=020", i, cap_gy[i]); end
    end
    checks++; if (cap_last[0] !== 1'b0) begin failures++; $display("FAIL ramp_last0 got=%b exp=0", cap_last[0]); end
    checks++; if (cap_last[1] !== 1'b1) begin failures++; $display("FAIL ramp_last1 got=%b exp=1", cap_last[1]); end
    checks++;
    if (acc_cyc[0] - pop_cyc[2 * W + 2] != 2) begin
      failures++; $display("FAIL ramp_latency got=%0d exp=2", acc_cyc[0] - pop_cyc[2 * W + 2]);
    end
  endtask

  task automatic test_negative();
    apply_reset();
    fill_ramp(1, 1'b1);
    drive(12, 1, 0, 200);
    checks++; if (cap_n != 2) begin failures++; $display("FAIL neg_count got=%0d exp=2", cap_n); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (cap_gx[i] !== 9'h1FE) begin failures++; $display("FAIL neg_gx[%0d] got=%h exp=1fe", i, cap_gx[i]); end
      checks++; if (cap_gy[i] !== 9'h1E0) begin failures++; $display("FAIL neg_gy[%0d] got=%h exp=1e0", i, cap_gy[i]); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    fill_ramp(1, 1'b0);
    drive(12, 1, 5, 200);
    checks++; if (stall_cycles != 5) begin failures++; $display("FAIL bp_stall_cycles got=%0d exp=5", stall_cycles); end
    checks++; if (stall_viol != 0) begin failures++; $display("FAIL bp_stability got=%0d exp=0", stall_viol); end
    checks++; if (cap_n != 2) begin failures++; $display("FAIL bp_count got=%0d exp=2", cap_n); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (cap_gx[i] !== 9'd2) begin failures++; $display("FAIL bp_gx[%0d] got=%h exp=002", i, cap_gx[i]); end
      checks++; if (cap_gy[i] !== 9'd32) begin failures++; $display("FAIL bp_gy[%0d] got=%h exp=020", i, cap_gy[i]); end
    end
    checks++; if (cap_last[1] !== 1'b1) begin failures++; $display("FAIL bp_last got=%b exp=1", cap_last[1]); end
  endtask

  task automatic test_sparse();
    apply_reset();
    fill_ramp(1, 1'b0);
    drive(12, 3, 0, 300);
    checks++; if (timed_out != 0) begin failures++; $display("FAIL sparse_timeout got=%0d exp=0", timed_out); end
    checks++; if (empty_pop != 0) begin failures++; $display("FAIL sparse_empty_pop got=%0d exp=0", empty_pop); end
    checks++; if (cap_n != 2) begin failures++; $display("FAIL sparse_count got=%0d exp=2", cap_n); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (cap_gx[i] !== 9'd2) begin failures++; $display("FAIL sparse_gx[%0d] got=%h exp=002", i, cap_gx[i]); end
      checks++; if (cap_gy[i] !== 9'd32) begin failures++; $display("FAIL sparse_gy[%0d] got=%h exp=020", i, cap_gy[i]); end
    end
    checks++; if (cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1) begin
      failures++; $display("FAIL sparse_last got=%b%b exp=01", cap_last[0], cap_last[1]);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    fill_ramp(1, 1'b0);
    drive(7, 1, 0, 200);
    checks++; if (cap_n != 0) begin failures++; $display("FAIL b2b_partial_count got=%0d exp=0", cap_n); end
    @(negedge clk);
    rst = 1'b1; rempty = 1'b0; rdata = 8'h77;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (rinc !== 1'b0) begin failures++; $display("FAIL b2b_reset_rinc got=%b exp=0", rinc); end
    rst = 1'b0; rempty = 1'b1;
    fill_ramp(2, 1'b0);
    drive(24, 1, 0, 300);
    checks++; if (cap_n != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", cap_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_gx[i] !== 9'd2 || cap_gy[i] !== 9'd32) begin
        failures++; $display("FAIL b2b_val[%0d] got=%h/%h exp=002/020", i, cap_gx[i], cap_gy[i]);
      end
      checks++; if (cap_last[i] !== ((i % 2) == 1)) begin
        failures++; $display("FAIL b2b_last[%0d] got=%b exp=%b", i, cap_last[i], (i % 2) == 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; rempty = 1'b1; rdata = 8'h00; out_ready = 1'b1;
    test_reset();
    test_ramp();
    test_negative();
    test_backpressure();
    test_sparse();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
